simd_wave_sequencer: RTL and testbench

- Per-SIMD control FSM that accepts one wave at a time from the wave dispatcher.
- Drives the SIMD state code consumed by that SIMD's PC: PC resets on dispatch_new_wave and increments while state is EXECUTE (3'b101).
- Sequences instruction fetch, decode and LSU memory completion for all lanes, then retires the wave on a RET instruction.
- Sits between the dispatcher, the program-memory fetch port, the decoder, the LSUs and the PC.

---
 rtl/simd_wave_sequencer.sv | 145 ++++++++++++++
 tb/tb_simd_wave_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_wave_sequencer.sv
// Per-SIMD wave sequencer: fetch, decode, LSU completion and wave retire.
// Optional perf counters are built in when SIMD_SEQ_PERF_CNT_EN is defined.
module simd_wave_sequencer #(
    parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
    parameter int NUM_LANES              = 4,
    parameter int WAVE_ID_WIDTH          = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              wave_valid,
    input  logic [WAVE_ID_WIDTH-1:0]          wave_id_in,
    output logic                              wave_ready,
    output logic                              dispatch_new_wave,
    input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_value,
    output logic                              fetch_req,
    output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] fetch_addr,
    input  logic                              fetch_ack,
    input  logic                              instr_is_mem,
    input  logic                              instr_is_ret,
    output logic                              mem_req,
    input  logic [NUM_LANES-1:0]              lsu_done,
    output logic [2:0]                        simd_state,
    output logic [WAVE_ID_WIDTH-1:0]          cur_wave_id,
    output logic                              busy,
    output logic                              wave_done
`ifdef SIMD_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                       instr_count,
    output logic [31:0]                       stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_LANES-1:0] lanes;
    logic [NUM_LANES-1:0] lanes_nxt;
    logic                 all_done;

    // A lane pulsing this cycle counts toward completion immediately.
    assign all_done   = &(lanes | lsu_done);
    assign simd_state = state;
    assign busy       = (state != S_IDLE);

    // State, lane collector and resident wave id registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lanes       <= '0;
            cur_wave_id <= '0;
        end else begin
            state <= state_nxt;
            lanes <= lanes_nxt;
            if (dispatch_new_wave)
                cur_wave_id <= wave_id_in;
        end
    end

    // Next-state and output decode; nothing advances while disabled.
    always_comb begin
        state_nxt         = state;
        lanes_nxt         = lanes;
        wave_ready        = 1'b0;
        dispatch_new_wave = 1'b0;
        mem_req           = 1'b0;
        wave_done         = 1'b0;
        fetch_req         = (state == S_FETCH);
        fetch_addr        = '0;
        if (state == S_FETCH)
            fetch_addr = pc_value;
        if (state == S_IDLE)
            wave_ready = enable;
        if (enable) begin
            unique case (state)
                S_IDLE: begin
                    if (wave_valid) begin
                        dispatch_new_wave = 1'b1;
                        state_nxt         = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_ack)
                        state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (instr_is_ret) begin
                        state_nxt = S_DONE;
                    end else if (instr_is_mem) begin
                        state_nxt = S_REQUEST;
                        lanes_nxt = '0;
                    end else begin
                        state_nxt = S_EXECUTE;
                    end
                end
                S_REQUEST: begin
                    mem_req   = 1'b1;
                    lanes_nxt = lanes | lsu_done;
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    lanes_nxt = lanes | lsu_done;
                    if (all_done)
                        state_nxt = S_EXECUTE;
                end
                S_EXECUTE: state_nxt = S_UPDATE;
                S_UPDATE:  state_nxt = S_FETCH;
                S_DONE: begin
                    wave_done = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef SIMD_SEQ_PERF_CNT_EN
    // Per-wave executed-instruction and LSU stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count  <= '0;
            stall_cycles <= '0;
        end else if (dispatch_new_wave) begin
            instr_count  <= '0;
            stall_cycles <= '0;
        end else if (enable) begin
            if (state == S_EXECUTE)
                instr_count <= instr_count + 32'd1;
            if (state == S_WAIT && !all_done)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simd_wave_sequencer.sv
// Randomized bench for simd_wave_sequencer against a per-wave trace model.
// The model expands an instruction list into the expected state per active cycle.
module tb_simd_wave_sequencer;
    localparam int AW = 32;
    localparam int NL = 4;
    localparam int WW = 4;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_REQ = 3;
    localparam int ST_WAIT = 4, ST_EXEC = 5, ST_UPD = 6, ST_DONE = 7;
    localparam int K_ALU = 0, K_MEM = 1, K_RET = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          wave_valid = 1'b0;
    logic [WW-1:0] wave_id_in = '0;
    logic          wave_ready;
    logic          dispatch_new_wave;
    logic [AW-1:0] pc_value;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ack = 1'b0;
    logic          instr_is_mem = 1'b0;
    logic          instr_is_ret = 1'b0;
    logic          mem_req;
    logic [NL-1:0] lsu_done = '0;
    logic [2:0]    simd_state;
    logic [WW-1:0] cur_wave_id;
    logic          busy;
    logic          wave_done;
`ifdef SIMD_SEQ_PERF_CNT_EN
    logic [31:0]   instr_count;
    logic [31:0]   stall_cycles;
`endif

    simd_wave_sequencer #(
        .PROGRAM_MEM_ADDR_WIDTH(AW),
        .NUM_LANES(NL),
        .WAVE_ID_WIDTH(WW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .wave_valid(wave_valid),
        .wave_id_in(wave_id_in),
        .wave_ready(wave_ready),
        .dispatch_new_wave(dispatch_new_wave),
        .pc_value(pc_value),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack),
        .instr_is_mem(instr_is_mem),
        .instr_is_ret(instr_is_ret),
        .mem_req(mem_req),
        .lsu_done(lsu_done),
        .simd_state(simd_state),
        .cur_wave_id(cur_wave_id),
        .busy(busy),
        .wave_done(wave_done)
`ifdef SIMD_SEQ_PERF_CNT_EN
        ,
        .instr_count(instr_count),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Environment PC: reset by dispatch, steps once per executed instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_value <= '0;
        else if (dispatch_new_wave)
            pc_value <= '0;
        else if (enable && simd_state == 3'(ST_EXEC))
            pc_value <= pc_value + 1;
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Expected trace, one entry per enabled cycle after dispatch.
    int q_st[$];
    int q_ack[$];
    int q_lsu[$];
    int q_mem[$];
    int q_ret[$];
    int q_pc[$];
    int exp_instr;
    int exp_stall;

    function automatic void push(int st, int ack, int lsu, int m, int r,
                                 int pc);
        q_st.push_back(st);
        q_ack.push_back(ack);
        q_lsu.push_back(lsu);
        q_mem.push_back(m);
        q_ret.push_back(r);
        q_pc.push_back(pc);
    endfunction

    function automatic int rnd(int n);
        return int'($urandom % n);
    endfunction

    // f[l]: offset of lane l's first pulse, 0 = REQUEST cycle, j = WAIT cycle j.
    task automatic add_instr(input int kind, input int pc, input int dly,
                             input logic [NL-1:0][3:0] f);
        int m;
        int bits;
        for (int k = 0; k <= dly; k++)
            push(ST_FETCH, (k == dly) ? 1 : 0, rnd(16), rnd(2), rnd(2), pc);
        push(ST_DECODE, rnd(2), rnd(16), kind == K_MEM, kind == K_RET, pc);
        if (kind == K_RET) begin
            push(ST_DONE, rnd(2), rnd(16), rnd(2), rnd(2), pc);
            return;
        end
        if (kind == K_MEM) begin
            m = 1;
            for (int l = 0; l < NL; l++)
                if (int'(f[l]) > m) m = int'(f[l]);
            for (int j = 0; j <= m; j++) begin
                bits = 0;
                for (int l = 0; l < NL; l++)
                    if (int'(f[l]) == j || (int'(f[l]) < j && rnd(2) == 1))
                        bits |= (1 << l);
                push((j == 0) ? ST_REQ : ST_WAIT, rnd(2), bits, rnd(2),
                     rnd(2), pc);
            end
            exp_stall += m - 1;
        end
        push(ST_EXEC, rnd(2), rnd(16), rnd(2), rnd(2), pc);
        push(ST_UPD, rnd(2), rnd(16), rnd(2), rnd(2), pc);
        exp_instr++;
    endtask

    function automatic void clear_model();
        q_st.delete();
        q_ack.delete();
        q_lsu.delete();
        q_mem.delete();
        q_ret.delete();
        q_pc.delete();
        exp_instr = 0;
        exp_stall = 0;
    endfunction

    task automatic dispatch(input int id);
        @(negedge clk);
        enable     = 1'b1;
        wave_valid = 1'b1;
        wave_id_in = WW'(id);
        fetch_ack  = 1'b0;
        lsu_done   = '0;
        #1;
        chk("disp_state", 64'(simd_state), ST_IDLE);
        chk("disp_ready", 64'(wave_ready), 1);
        chk("disp_strobe", 64'(dispatch_new_wave), 1);
    endtask

    // Replays the expected trace; disabled cycles must freeze everything.
    task automatic run_wave(input int id, input bit en_rand);
        int idx = 0;
        int st;
        bit en;
        dispatch(id);
        while (idx < q_st.size()) begin
            @(negedge clk);
            en = en_rand ? (rnd(5) != 0) : 1'b1;
            enable     = en;
            wave_valid = rnd(2) == 1;
            wave_id_in = WW'(rnd(16));
            if (en) begin
                fetch_ack    = q_ack[idx] != 0;
                lsu_done     = NL'(q_lsu[idx]);
                instr_is_mem = q_mem[idx] != 0;
                instr_is_ret = q_ret[idx] != 0;
            end else begin
                fetch_ack    = rnd(2) == 1;
                lsu_done     = NL'(rnd(16));
                instr_is_mem = rnd(2) == 1;
                instr_is_ret = rnd(2) == 1;
            end
            #1;
            st = q_st[idx];
            chk("state", 64'(simd_state), 64'(st));
            chk("busy", 64'(busy), 1);
            chk("fetch_req", 64'(fetch_req), 64'(st == ST_FETCH));
            if (st == ST_FETCH)
                chk("fetch_addr", 64'(fetch_addr), 64'(q_pc[idx]));
            chk("mem_req", 64'(mem_req), 64'(en && st == ST_REQ));
            chk("wave_done", 64'(wave_done), 64'(en && st == ST_DONE));
            chk("ready_busy", 64'(wave_ready), 0);
            chk("no_dispatch", 64'(dispatch_new_wave), 0);
            chk("wave_id", 64'(cur_wave_id), 64'(id));
            if (en) idx++;
        end
        @(negedge clk);
        enable     = 1'b1;
        wave_valid = 1'b0;
        lsu_done   = '0;
        #1;
        chk("end_state", 64'(simd_state), ST_IDLE);
        chk("end_busy", 64'(busy), 0);
        chk("end_ready", 64'(wave_ready), 1);
`ifdef SIMD_SEQ_PERF_CNT_EN
        chk("instr_count", 64'(instr_count), 64'(exp_instr));
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
`endif
    endtask

    logic [NL-1:0][3:0] f_zero;
    logic [NL-1:0][3:0] f_dir;
    logic [NL-1:0][3:0] f_rnd;

    initial begin
        int n;
        int kind;
        f_zero = '0;

        #1;
        chk("rst_state", 64'(simd_state), ST_IDLE);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_id", 64'(cur_wave_id), 0);
        chk("rst_ready_dis", 64'(wave_ready), 0);
        enable = 1'b1;
        #1;
        chk("rst_ready_en", 64'(wave_ready), 1);
        chk("rst_fetch_req", 64'(fetch_req), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two ALU ops then RET with immediate acks.
        clear_model();
        add_instr(K_ALU, 0, 0, f_zero);
        add_instr(K_ALU, 1, 0, f_zero);
        add_instr(K_RET, 2, 0, f_zero);
        run_wave(3, 1'b0);

        // Load: lanes 0,2 arrive in WAIT cycle 2, lanes 1,3 in cycle 5.
        clear_model();
        f_dir = {4'd5, 4'd2, 4'd5, 4'd2};
        add_instr(K_MEM, 0, 0, f_dir);
        add_instr(K_ALU, 1, 3, f_zero);
        add_instr(K_RET, 2, 0, f_zero);
        run_wave(9, 1'b0);

        // Reset while executing.
        @(negedge clk);
        enable       = 1'b1;
        wave_valid   = 1'b1;
        wave_id_in   = 4'd5;
        fetch_ack    = 1'b1;
        instr_is_mem = 1'b0;
        instr_is_ret = 1'b0;
        @(negedge clk);
        wave_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_exec", 64'(simd_state), ST_EXEC);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 64'(simd_state), ST_IDLE);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_id", 64'(cur_wave_id), 0);
        chk("mid_rst_ready", 64'(wave_ready), 1);
        enable = 1'b0;
        #1;
        chk("mid_rst_ready_dis", 64'(wave_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        clear_model();
        add_instr(K_ALU, 0, 1, f_zero);
        add_instr(K_RET, 1, 0, f_zero);
        run_wave(7, 1'b0);

        // Random waves with random enable gaps.
        for (int w = 0; w < 40; w++) begin
            clear_model();
            n = rnd(6);
            for (int i = 0; i < n; i++) begin
                kind = rnd(2);
                for (int l = 0; l < NL; l++)
                    f_rnd[l] = 4'(rnd(7));
                add_instr(kind, i, rnd(4), f_rnd);
            end
            add_instr(K_RET, n, rnd(4), f_zero);
            run_wave(rnd(16), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
